lsu_bus_arbiter: RTL
====================

# lsu_bus_arbiter

Shares the single data-memory bus port between the LSU's load path and the store buffer's committed-store drain path. Sits between `execute_lsu`/store buffer and the memory bus. Runs a three-state-plus-drop FSM that issues one bus transaction at a time. Loads win by default, and a starvation counter guarantees forward progress for committed stores. Pipeline flushes abort in-flight loads but never abort committed stores.

## Interface

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH` (32): address width
- BUS_DATA_WIDTH, `BUS_DATA_WIDTH` (32): bus data width
- SIZE_WIDTH, `SIZE_WIDTH` (2): access size code; 00 = byte, 01 = half, 10 = word
- STARVE_LIMIT, 4: maximum consecutive load grants while a store is pending; range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- load_req  in  1  load request; level signal, held until load_ready or flush
- load_addr  in  ADDR_WIDTH  load address
- load_size  in  SIZE_WIDTH  load size
- load_ready  out  1  one-cycle pulse; load_data valid
- load_data  out  BUS_DATA_WIDTH  registered bus read data
- store_valid  in  1  store-buffer head entry is committed and drainable
- store_addr  in  ADDR_WIDTH  head entry address
- store_size  in  SIZE_WIDTH  head entry size
- store_data  in  BUS_DATA_WIDTH  head entry data
- store_pop  out  1  one-cycle pulse; head entry retired
- flush  in  1  commit feedback flush (enable && flush)
- bus_req  out  1  bus transaction request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_WIDTH  transaction address
- bus_size  out  SIZE_WIDTH  transaction size
- bus_wdata  out  BUS_DATA_WIDTH  write data
- bus_ack  in  1  transaction complete; read data valid the same cycle
- bus_rdata  in  BUS_DATA_WIDTH  read data

## Operation

- States: IDLE, LOAD_WAIT, STORE_WAIT, LOAD_DROP.
- Grant is evaluated in IDLE only:
  - load_eff = load_req && !flush.
  - Store wins if store_valid and either !load_eff or starve_cnt == STARVE_LIMIT.
  - Otherwise a load wins if load_eff.
  - Otherwise the FSM stays in IDLE.
- On a load grant:
  - Register the addr/size onto bus_*.
  - bus_we = 0, bus_req = 1.
  - Go to LOAD_WAIT.
  - If store_valid, starve_cnt increments (saturating at STARVE_LIMIT).
- On a store grant:
  - Register addr/size/data.
  - bus_we = 1, bus_req = 1.
  - Go to STORE_WAIT.
  - starve_cnt resets to 0.
- starve_cnt also resets to 0 in any cycle where store_valid = 0.
- LOAD_WAIT:
  - bus_ack && !flush: capture bus_rdata into load_data, load_ready = 1 next cycle, go to IDLE.
  - bus_ack && flush: go to IDLE with no load_ready.
  - flush && !bus_ack: go to LOAD_DROP.
- LOAD_DROP:
  - bus_req stays 1 with address unchanged until bus_ack.
  - The read data is discarded and the FSM returns to IDLE.
  - No load_ready is produced.
- STORE_WAIT:
  - On bus_ack, store_pop = 1 next cycle and the FSM returns to IDLE.
  - flush is ignored because the store is already committed.
- bus_req drops in the cycle after bus_ack. bus_addr/bus_size/bus_wdata/bus_we hold their values while bus_req = 1.
- The store buffer must not change its head fields while STORE_WAIT is active. Stores are captured at grant, so later changes are harmless.
- Reset values (rst = 0 at an edge):
  - state = IDLE, starve_cnt = 0.
  - bus_req = 0, bus_we = 0, bus_addr = 0, bus_size = 0, bus_wdata = 0.
  - load_ready = 0, load_data = 0, store_pop = 0.
  - Reset mid-transaction abandons it. The bus slave is reset on the same domain.

## Timing

- Grant at edge N (IDLE): bus_req = 1 from cycle N+1.
- bus_ack sampled at edge M: load_ready or store_pop = 1 during cycle M+1, and bus_req = 0 during M+1.
- The next grant can be evaluated at edge M+1, giving bus_req again in M+2. Back-to-back throughput is one transaction per 3 cycles with a zero-wait slave.
- Minimum load latency, from load_req first high to load_ready: 3 cycles with an immediate ack.
- load_ready and store_pop are single-cycle pulses and never assert in the same cycle.
- bus_ack outside LOAD_WAIT, STORE_WAIT or LOAD_DROP is ignored.

## Test plan

- Reset and load: hold rst = 0 for 2 cycles and check every output is 0. Release, then load_req with addr 0x100, size 10, and bus_ack one cycle after bus_req with rdata 0xDEADBEEF. Expect bus_we = 0, bus_addr = 0x100, one load_ready pulse with load_data 0xDEADBEEF.
- Store drain: store_valid with addr 0x200, data 0x12, size 00, and ack after 3 wait cycles. Expect bus_we = 1, bus_wdata = 0x12 held for 4 cycles, then a single store_pop.
- Starvation, STARVE_LIMIT = 4: load_req and store_valid both held continuously with immediate acks. Expect the grant order L, L, L, L, S, L…, with store_pop after the 4th load_ready.
- Flush mid-load: flush in the cycle after bus_req rises, ack 2 cycles later. Expect bus_req held until ack, no load_ready, and a return to IDLE. A new load_req is then served normally.
- Flush during a store: flush pulses in STORE_WAIT. Expect the store to complete and store_pop to assert.
- Flush in IDLE with load_req and no store: expect no grant that cycle, and bus_req to stay 0.

Source files
------------

// File: rtl/lsu_bus_arbiter.sv
// Arbitrates the single data-memory bus port between LSU loads and committed-store drain.
// Loads win by default; a starvation counter forces a store grant after STARVE_LIMIT loads.
module lsu_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int SIZE_WIDTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_req,
  input  logic [ADDR_WIDTH-1:0]     load_addr,
  input  logic [SIZE_WIDTH-1:0]     load_size,
  output logic                      load_ready,
  output logic [BUS_DATA_WIDTH-1:0] load_data,
  input  logic                      store_valid,
  input  logic [ADDR_WIDTH-1:0]     store_addr,
  input  logic [SIZE_WIDTH-1:0]     store_size,
  input  logic [BUS_DATA_WIDTH-1:0] store_data,
  output logic                      store_pop,
  input  logic                      flush,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [SIZE_WIDTH-1:0]     bus_size,
  output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
  input  logic                      bus_ack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2,
    LOAD_DROP  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                    state_q, state_d;
  logic [3:0]                starve_q, starve_d;
  logic                      bus_req_q, bus_req_d;
  logic                      bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0]     bus_addr_q, bus_addr_d;
  logic [SIZE_WIDTH-1:0]     bus_size_q, bus_size_d;
  logic [BUS_DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                      load_ready_q, load_ready_d;
  logic [BUS_DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                      store_pop_q, store_pop_d;

  logic load_eff;
  logic store_win;

  // A load being flushed this cycle must not win the bus.
  assign load_eff  = load_req && !flush;
  assign store_win = store_valid && (!load_eff || (starve_q == LIMIT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_size_q   <= '0;
      bus_wdata_q  <= '0;
      load_ready_q <= 1'b0;
      load_data_q  <= '0;
      store_pop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_size_q   <= bus_size_d;
      bus_wdata_q  <= bus_wdata_d;
      load_ready_q <= load_ready_d;
      load_data_q  <= load_data_d;
      store_pop_q  <= store_pop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_size_d   = bus_size_q;
    bus_wdata_d  = bus_wdata_q;
    load_ready_d = 1'b0;
    load_data_d  = load_data_q;
    store_pop_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (store_win) begin
          state_d     = STORE_WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = store_addr;
          bus_size_d  = store_size;
          bus_wdata_d = store_data;
          starve_d    = '0;
        end else if (load_eff) begin
          state_d    = LOAD_WAIT;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = load_addr;
          bus_size_d = load_size;
          if (store_valid && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      LOAD_WAIT: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (!flush) begin
            load_data_d  = bus_rdata;
            load_ready_d = 1'b1;
          end
        end else if (flush) begin
          state_d = LOAD_DROP;
        end
      end
      // The bus cannot cancel a read, so keep it alive and discard the data.
      LOAD_DROP: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      STORE_WAIT: begin
        if (bus_ack) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          store_pop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!store_valid) begin
      starve_d = '0;
    end
  end

  assign load_ready = load_ready_q;
  assign load_data  = load_data_q;
  assign store_pop  = store_pop_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_size   = bus_size_q;
  assign bus_wdata  = bus_wdata_q;

endmodule
